// File: rtl/vga_timing_pkg.sv
// Shared raster timing definitions: mode constant sets and a timing-parameter struct.
package vga_timing_pkg;

  typedef struct packed {
    logic [15:0] h_active;
    logic [15:0] h_fp;
    logic [15:0] h_sync;
    logic [15:0] h_bp;
    logic [15:0] v_active;
    logic [15:0] v_fp;
    logic [15:0] v_sync;
    logic [15:0] v_bp;
    logic        hs_pol;
    logic        vs_pol;
  } vga_timing_t;

  // 640x480 @ 25.175 MHz, negative syncs
  localparam vga_timing_t VGA_640X480 = '{
    h_active: 16'd640, h_fp: 16'd16, h_sync: 16'd96, h_bp: 16'd48,
    v_active: 16'd480, v_fp: 16'd10, v_sync: 16'd2,  v_bp: 16'd33,
    hs_pol:   1'b0,    vs_pol: 1'b0
  };

  // 800x600 @ 40 MHz, positive syncs
  localparam vga_timing_t VGA_800X600 = '{
    h_active: 16'd800, h_fp: 16'd40, h_sync: 16'd128, h_bp: 16'd88,
    v_active: 16'd600, v_fp: 16'd1,  v_sync: 16'd4,   v_bp: 16'd23,
    hs_pol:   1'b1,    vs_pol: 1'b1
  };

  function automatic int unsigned vga_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the timing generator to renderer / VGA output stage.
interface vga_timing_gen_if #(
  parameter int unsigned X_W     = 10,
  parameter int unsigned Y_W     = 10,
  parameter int unsigned FRAME_W = 16
);
  logic               o_hs;
  logic               o_vs;
  logic               o_active;
  logic               o_blanking;
  logic [X_W-1:0]     o_x;
  logic [Y_W-1:0]     o_y;
  logic               o_line_start;
  logic               o_frame_start;
  logic               o_animate;
  logic               o_screenend;
  logic [FRAME_W-1:0] o_frame_cnt;
  logic               o_hs_d;
  logic               o_vs_d;
  logic               o_active_d;

  modport master (
    output o_hs, o_vs, o_active, o_blanking, o_x, o_y,
           o_line_start, o_frame_start, o_animate, o_screenend,
           o_frame_cnt, o_hs_d, o_vs_d, o_active_d
  );

  modport slave (
    input  o_hs, o_vs, o_active, o_blanking, o_x, o_y,
           o_line_start, o_frame_start, o_animate, o_screenend,
           o_frame_cnt, o_hs_d, o_vs_d, o_active_d
  );
endinterface

// File: rtl/vga_delay_line.sv
// Enable-gated shift register with async reset and synchronous flush to IDLE.
module vga_delay_line #(
  parameter int unsigned       WIDTH = 3,
  parameter int unsigned       DEPTH = 2,
  parameter logic [WIDTH-1:0]  IDLE  = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  if (DEPTH == 0) begin : g_pass
    logic unused_c;
    assign unused_c = ^{i_clk, i_rst_n, i_en, i_flush};
    assign o_q      = i_d;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    // Flush wins over shift so a restart always leaves idle values behind.
    always_comb begin
      stage_d = stage_q;
      if (i_flush) begin
        for (int i = 0; i < int'(DEPTH); i++) stage_d[i] = IDLE;
      end else if (i_en) begin
        stage_d[0] = i_d;
        for (int i = 1; i < int'(DEPTH); i++) stage_d[i] = stage_q[i-1];
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= IDLE;
      end else begin
        stage_q <= stage_d;
      end
    end

    assign o_q = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: h/v counters, sync/active decode, strobes,
// completed-frame counter and a delay line aligning syncs with the pixel pipeline.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 32'(VGA_640X480.h_active),
  parameter int unsigned H_FP     = 32'(VGA_640X480.h_fp),
  parameter int unsigned H_SYNC   = 32'(VGA_640X480.h_sync),
  parameter int unsigned H_BP     = 32'(VGA_640X480.h_bp),
  parameter int unsigned V_ACTIVE = 32'(VGA_640X480.v_active),
  parameter int unsigned V_FP     = 32'(VGA_640X480.v_fp),
  parameter int unsigned V_SYNC   = 32'(VGA_640X480.v_sync),
  parameter int unsigned V_BP     = 32'(VGA_640X480.v_bp),
  parameter bit          HS_POL   = VGA_640X480.hs_pol,
  parameter bit          VS_POL   = VGA_640X480.vs_pol,
  parameter int unsigned PIPE_DLY = 2,
  parameter int unsigned X_W      = 10,
  parameter int unsigned Y_W      = 10,
  parameter int unsigned FRAME_W  = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clkenable,
  input  logic             i_restart,
  vga_timing_gen_if.master vga
);

  localparam int unsigned H_TOTAL  = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL  = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
      X_W == 0 || Y_W == 0 || FRAME_W == 0) begin : g_bad_zero
    $error("vga_timing_gen: timing and width parameters must be non-zero");
  end
  if (((H_TOTAL - 1) >> X_W) != 0 || ((V_TOTAL - 1) >> Y_W) != 0) begin : g_bad_width
    $error("vga_timing_gen: counter width too small for total line/frame length");
  end

  logic [X_W-1:0]     h_q, h_d;
  logic [Y_W-1:0]     v_q, v_d;
  logic [FRAME_W-1:0] frame_q, frame_d;

  logic strobe_en_c;
  logic h_last_c;
  logic v_last_c;
  logic line_start_c;
  logic frame_start_c;
  logic animate_c;
  logic screenend_c;
  logic hs_c;
  logic vs_c;
  logic active_c;
  logic [2:0] dly_q_c;

  // Decode and next-state; restart has priority over the pixel strobe.
  always_comb begin
    strobe_en_c   = i_rst_n & i_clkenable & ~i_restart;
    h_last_c      = (h_q == X_W'(H_TOTAL - 1));
    v_last_c      = (v_q == Y_W'(V_TOTAL - 1));
    line_start_c  = strobe_en_c & (h_q == '0);
    frame_start_c = line_start_c & (v_q == '0);
    animate_c     = strobe_en_c & h_last_c & (v_q == Y_W'(V_ACTIVE - 1));
    screenend_c   = strobe_en_c & h_last_c & v_last_c;

    hs_c     = ((h_q >= X_W'(HS_START)) && (h_q < X_W'(HS_END))) ? HS_POL : ~HS_POL;
    vs_c     = ((v_q >= Y_W'(VS_START)) && (v_q < Y_W'(VS_END))) ? VS_POL : ~VS_POL;
    active_c = (h_q < X_W'(H_ACTIVE)) && (v_q < Y_W'(V_ACTIVE));

    h_d     = h_q;
    v_d     = v_q;
    frame_d = frame_q;
    if (i_restart) begin
      h_d = '0;
      v_d = '0;
    end else if (i_clkenable) begin
      if (h_last_c) begin
        h_d = '0;
        v_d = v_last_c ? '0 : v_q + Y_W'(1);
      end else begin
        h_d = h_q + X_W'(1);
      end
      if (screenend_c) frame_d = frame_q + FRAME_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_q     <= '0;
      v_q     <= '0;
      frame_q <= '0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      frame_q <= frame_d;
    end
  end

  vga_delay_line #(
    .WIDTH (3),
    .DEPTH (PIPE_DLY),
    .IDLE  ({~HS_POL, ~VS_POL, 1'b0})
  ) u_dly (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (i_clkenable),
    .i_flush (i_restart),
    .i_d     ({hs_c, vs_c, active_c}),
    .o_q     (dly_q_c)
  );

  assign vga.o_hs          = hs_c;
  assign vga.o_vs          = vs_c;
  assign vga.o_active      = active_c;
  assign vga.o_blanking    = ~active_c;
  assign vga.o_x           = (h_q < X_W'(H_ACTIVE)) ? h_q : X_W'(H_ACTIVE - 1);
  assign vga.o_y           = (v_q < Y_W'(V_ACTIVE)) ? v_q : Y_W'(V_ACTIVE - 1);
  assign vga.o_line_start  = line_start_c;
  assign vga.o_frame_start = frame_start_c;
  assign vga.o_animate     = animate_c;
  assign vga.o_screenend   = screenend_c;
  assign vga.o_frame_cnt   = frame_q;
  assign vga.o_hs_d        = dly_q_c[2];
  assign vga.o_vs_d        = dly_q_c[1];
  assign vga.o_active_d    = dly_q_c[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 timing plus a tiny positive-sync mode at PIPE_DLY 3 and 0.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n_d, en_d, rs_d;
  logic rst_n_s, en_s, rs_s;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.X_W(10), .Y_W(10), .FRAME_W(16)) d_if ();
  vga_timing_gen_if #(.X_W(4),  .Y_W(3),  .FRAME_W(2))  s_if ();
  vga_timing_gen_if #(.X_W(4),  .Y_W(3),  .FRAME_W(2))  z_if ();

  vga_timing_gen #(.PIPE_DLY(2)) u_d (
    .i_clk(clk), .i_rst_n(rst_n_d), .i_clkenable(en_d), .i_restart(rs_d), .vga(d_if)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DLY(3), .X_W(4), .Y_W(3), .FRAME_W(2)
  ) u_s (
    .i_clk(clk), .i_rst_n(rst_n_s), .i_clkenable(en_s), .i_restart(rs_s), .vga(s_if)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DLY(0), .X_W(4), .Y_W(3), .FRAME_W(2)
  ) u_z (
    .i_clk(clk), .i_rst_n(rst_n_s), .i_clkenable(en_s), .i_restart(rs_s), .vga(z_if)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int hs_low, hs_first, ls_cnt;
  logic [31:0] x639, x700, act639, act640, blank640;
  int st0, st1, ls_hi, ls_dbl, ls_noen;
  logic ls_prev;
  int bad_act, bad_sd, bad_zd, an_cnt, an_first, se_cnt, se_first;
  int shs_cnt, shs_first;
  logic [31:0] vs69, vs70, vs83, vs84, sx10, sy70, sfs0;
  logic [31:0] fc_seq [5];
  bit act_hist [0:490];

  initial begin
    rst_n_d = 1'b0; en_d = 1'b0; rs_d = 1'b0;
    rst_n_s = 1'b0; en_s = 1'b0; rs_s = 1'b0;
    step(2);

    // Reset state, default mode
    chk("d_rst_x", d_if.o_x, 0);
    chk("d_rst_y", d_if.o_y, 0);
    chk("d_rst_active", d_if.o_active, 1);
    chk("d_rst_blank", d_if.o_blanking, 0);
    chk("d_rst_hs", d_if.o_hs, 1);
    chk("d_rst_vs", d_if.o_vs, 1);
    chk("d_rst_fcnt", d_if.o_frame_cnt, 0);
    chk("d_rst_hs_d", d_if.o_hs_d, 1);
    chk("d_rst_vs_d", d_if.o_vs_d, 1);
    chk("d_rst_act_d", d_if.o_active_d, 0);
    chk("s_rst_hs", s_if.o_hs, 0);
    chk("s_rst_hs_d", s_if.o_hs_d, 0);
    en_d = 1'b1;
    #1;
    chk("d_rst_fs_gated", d_if.o_frame_start, 0);
    chk("d_rst_ls_gated", d_if.o_line_start, 0);
    rst_n_d = 1'b1;
    #1;
    chk("d_first_fs", d_if.o_frame_start, 1);
    chk("d_first_ls", d_if.o_line_start, 1);

    // One full default line with the pixel strobe held high
    hs_low = 0; hs_first = -1; ls_cnt = 0;
    x639 = '0; x700 = '0; act639 = '0; act640 = '0; blank640 = '0;
    for (int k = 0; k < 800; k++) begin
      if (d_if.o_hs == 1'b0) begin
        if (hs_first < 0) hs_first = k;
        hs_low++;
      end
      if (d_if.o_line_start) ls_cnt++;
      if (k == 639) begin x639 = 32'(d_if.o_x); act639 = 32'(d_if.o_active); end
      if (k == 640) begin act640 = 32'(d_if.o_active); blank640 = 32'(d_if.o_blanking); end
      if (k == 700) x700 = 32'(d_if.o_x);
      step(1);
    end
    chk("d_hs_low_cycles", 32'(hs_low), 96);
    chk("d_hs_first_h", 32'(hs_first), 656);
    chk("d_ls_per_line", 32'(ls_cnt), 1);
    chk("d_x_at_639", x639, 639);
    chk("d_x_sat_700", x700, 639);
    chk("d_act_639", act639, 1);
    chk("d_act_640", act640, 0);
    chk("d_blank_640", blank640, 1);
    chk("d_line1_y", d_if.o_y, 1);
    chk("d_line1_ls", d_if.o_line_start, 1);
    chk("d_line1_fs", d_if.o_frame_start, 0);
    chk("d_line1_act_d", d_if.o_active_d, 0);
    step(2);
    chk("d_h2_act_d", d_if.o_active_d, 1);

    // Pixel strobe 1-in-4: starting at h=2, v=1
    st0 = -1; st1 = -1; ls_hi = 0; ls_dbl = 0; ls_noen = 0; ls_prev = 1'b0;
    for (int c = 0; c < 7000; c++) begin
      en_d = (c % 4 == 0);
      #1;
      if (d_if.o_line_start) begin
        ls_hi++;
        if (st0 < 0) st0 = c; else if (st1 < 0) st1 = c;
        if (ls_prev) ls_dbl++;
        if (!en_d) ls_noen++;
      end
      ls_prev = d_if.o_line_start;
      @(posedge clk);
      #1;
    end
    en_d = 1'b1;
    chk("d_div4_first_ls", 32'(st0), 3192);
    chk("d_div4_line_cycles", 32'(st1 - st0), 3200);
    chk("d_div4_ls_count", 32'(ls_hi), 2);
    chk("d_div4_ls_wide", 32'(ls_dbl), 0);
    chk("d_div4_ls_noen", 32'(ls_noen), 0);

    // Restart mid-line at h=300, v=3
    step(148);
    chk("d_pre_rs_x", d_if.o_x, 300);
    chk("d_pre_rs_y", d_if.o_y, 3);
    chk("d_pre_rs_act_d", d_if.o_active_d, 1);
    rs_d = 1'b1;
    #1;
    chk("d_rs_cycle_ls", d_if.o_line_start, 0);
    step(1);
    rs_d = 1'b0;
    #1;
    chk("d_post_rs_x", d_if.o_x, 0);
    chk("d_post_rs_y", d_if.o_y, 0);
    chk("d_post_rs_fs", d_if.o_frame_start, 1);
    chk("d_post_rs_act_d", d_if.o_active_d, 0);
    chk("d_post_rs_hs_d", d_if.o_hs_d, 1);
    chk("d_post_rs_vs_d", d_if.o_vs_d, 1);
    chk("d_post_rs_fcnt", d_if.o_frame_cnt, 0);
    step(1);
    chk("d_rs_tick1_act_d", d_if.o_active_d, 0);
    chk("d_rs_tick1_x", d_if.o_x, 1);
    step(1);
    chk("d_rs_tick2_act_d", d_if.o_active_d, 1);

    // Restart landing on (0,0) suppresses the frame strobe in its own cycle
    rs_d = 1'b1;
    step(1);
    chk("d_rs_origin_fs", d_if.o_frame_start, 0);
    chk("d_rs_origin_ls", d_if.o_line_start, 0);
    rs_d = 1'b0;
    #1;
    chk("d_rs_origin_fs_after", d_if.o_frame_start, 1);

    // Pixel strobe low: everything holds, strobes quiet
    en_d = 1'b0;
    #1;
    chk("d_hold_ls", d_if.o_line_start, 0);
    step(5);
    chk("d_hold_x", d_if.o_x, 0);
    chk("d_hold_fs", d_if.o_frame_start, 0);
    en_d = 1'b1;
    #1;
    chk("d_hold_release_fs", d_if.o_frame_start, 1);

    // Small mode, 5 frames of 14x7 with strobe held high
    step(1);
    rst_n_s = 1'b1;
    en_s    = 1'b1;
    #1;
    bad_act = 0; bad_sd = 0; bad_zd = 0;
    an_cnt = 0; an_first = -1; se_cnt = 0; se_first = -1;
    shs_cnt = 0; shs_first = -1;
    vs69 = '0; vs70 = '0; vs83 = '0; vs84 = '0; sx10 = '0; sy70 = '0; sfs0 = '0;
    for (int k = 0; k <= 490; k++) begin
      int h, v;
      bit exp_act, exp_sd;
      h = k % 14;
      v = (k / 14) % 7;
      exp_act = (h < 8) && (v < 4);
      act_hist[k] = exp_act;
      exp_sd = (k < 3) ? 1'b0 : act_hist[k-3];
      if (s_if.o_active !== exp_act) bad_act++;
      if (s_if.o_active_d !== exp_sd) bad_sd++;
      if (z_if.o_active_d !== exp_act) bad_zd++;
      if (k < 14 && s_if.o_hs) begin
        shs_cnt++;
        if (shs_first < 0) shs_first = h;
      end
      if (s_if.o_animate) begin
        an_cnt++;
        if (an_first < 0) an_first = k;
      end
      if (s_if.o_screenend) begin
        se_cnt++;
        if (se_first < 0) se_first = k;
      end
      if (k == 0)  sfs0 = 32'(s_if.o_frame_start);
      if (k == 10) sx10 = 32'(s_if.o_x);
      if (k == 69) vs69 = 32'(s_if.o_vs);
      if (k == 70) begin vs70 = 32'(s_if.o_vs); sy70 = 32'(s_if.o_y); end
      if (k == 83) vs83 = 32'(s_if.o_vs);
      if (k == 84) vs84 = 32'(s_if.o_vs);
      if (k > 0 && k % 98 == 0) fc_seq[k/98 - 1] = 32'(s_if.o_frame_cnt);
      step(1);
    end
    chk("s_first_fs", sfs0, 1);
    chk("s_active_pattern_errs", 32'(bad_act), 0);
    chk("s_act_d3_errs", 32'(bad_sd), 0);
    chk("z_act_d0_errs", 32'(bad_zd), 0);
    chk("s_hs_high_cycles", 32'(shs_cnt), 2);
    chk("s_hs_first_h", 32'(shs_first), 10);
    chk("s_vs_line4", vs69, 0);
    chk("s_vs_line5_start", vs70, 1);
    chk("s_vs_line5_end", vs83, 1);
    chk("s_vs_line6", vs84, 0);
    chk("s_x_sat", sx10, 7);
    chk("s_y_sat", sy70, 3);
    chk("s_animate_first", 32'(an_first), 55);
    chk("s_animate_count", 32'(an_cnt), 5);
    chk("s_screenend_first", 32'(se_first), 97);
    chk("s_screenend_count", 32'(se_cnt), 5);
    chk("s_fcnt_f1", fc_seq[0], 1);
    chk("s_fcnt_f2", fc_seq[1], 2);
    chk("s_fcnt_f3", fc_seq[2], 3);
    chk("s_fcnt_f4_wrap", fc_seq[3], 0);
    chk("s_fcnt_f5", fc_seq[4], 1);

    // Restart keeps the frame count; pass-through copy follows undelayed value
    rs_s = 1'b1;
    step(1);
    rs_s = 1'b0;
    #1;
    chk("s_rs_x", s_if.o_x, 0);
    chk("s_rs_fs", s_if.o_frame_start, 1);
    chk("s_rs_fcnt", s_if.o_frame_cnt, 1);
    chk("s_rs_act_d", s_if.o_active_d, 0);
    chk("s_rs_hs_d", s_if.o_hs_d, 0);
    chk("z_rs_act_d", z_if.o_active_d, 1);

    // Async reset mid-line takes effect without a clock edge
    step(3);
    chk("s_pre_rst_x", s_if.o_x, 3);
    #2;
    rst_n_s = 1'b0;
    #1;
    chk("s_arst_x", s_if.o_x, 0);
    chk("s_arst_y", s_if.o_y, 0);
    chk("s_arst_fcnt", s_if.o_frame_cnt, 0);
    chk("s_arst_active", s_if.o_active, 1);
    chk("s_arst_blank", s_if.o_blanking, 0);
    chk("s_arst_hs", s_if.o_hs, 0);
    chk("s_arst_vs", s_if.o_vs, 0);
    chk("s_arst_ls", s_if.o_line_start, 0);
    chk("s_arst_fs", s_if.o_frame_start, 0);
    chk("s_arst_hs_d", s_if.o_hs_d, 0);
    chk("s_arst_vs_d", s_if.o_vs_d, 0);
    chk("s_arst_act_d", s_if.o_active_d, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised raster timing generator, the successor to the fixed 640x480 timing block in the VGA path. Horizontal and vertical geometry and sync polarity are set by parameters. Adds a frame counter, line/frame start strobes, a synchronous restart, and a configurable delay line that aligns syncs with a downstream pixel pipeline. It sits between the clock-enable divider and the pinball renderer/VGA output stage.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- HS_POL, 0, asserted level of o_hs/o_hs_d (0 = active-low)
- VS_POL, 0, asserted level of o_vs/o_vs_d
- PIPE_DLY, 2, delay-line depth in pixel ticks (0 = pass-through)
- X_W, 10, width of o_x and h counter; Y_W, 10, width of o_y and v counter
- FRAME_W, 16, frame counter width
- i_clk  in  1  base clock
- i_rst_n  in  1  asynchronous active-low reset
- i_clkenable  in  1  pixel strobe; all counting advances only when high
- i_restart  in  1  synchronous restart to pixel (0,0)
- o_hs, o_vs  out  1  sync, undelayed
- o_active  out  1  high in visible region; o_blanking  out  1  its complement
- o_x  out  X_W  pixel column; o_y  out  Y_W  pixel row
- o_line_start  out  1  one-cycle strobe at start of every line
- o_frame_start  out  1  one-cycle strobe at (0,0)
- o_animate  out  1  one-cycle strobe after last visible pixel of frame
- o_screenend  out  1  one-cycle strobe after last pixel of frame
- o_frame_cnt  out  FRAME_W  completed-frame count
- o_hs_d, o_vs_d, o_active_d  out  1  outputs delayed by PIPE_DLY ticks

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Elaboration error if any parameter is 0 (except PIPE_DLY), or if H_TOTAL-1 exceeds X_W bits or V_TOTAL-1 exceeds Y_W bits.
- Line order: active [0, H_ACTIVE), FP, sync, BP. Same for vertical.
- h_cnt counts 0..H_TOTAL-1 exactly. On wrap, v_cnt advances and counts 0..V_TOTAL-1 exactly.
- o_hs = HS_POL when h_cnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), else ~HS_POL. o_vs is defined the same way on v_cnt.
- o_active = (h_cnt<H_ACTIVE)&(v_cnt<V_ACTIVE).
- o_x = min(h_cnt, H_ACTIVE-1); o_y = min(v_cnt, V_ACTIVE-1).
- Strobes are gated with i_clkenable:
  - line_start: h=0.
  - frame_start: h=0, v=0.
  - animate: h=H_TOTAL-1, v=V_ACTIVE-1.
  - screenend: h=H_TOTAL-1, v=V_TOTAL-1.
- o_frame_cnt increments on o_screenend and wraps modulo 2^FRAME_W.
- i_restart has priority over i_clkenable. It forces h_cnt=v_cnt=0, flushes the delay line to idle values, and leaves o_frame_cnt unchanged. No strobes fire in the restart cycle.
- Delay line: PIPE_DLY stages of {hs, vs, active}, shifting only on i_clkenable. Idle value is {~HS_POL, ~VS_POL, 0}.

## Timing
- Counters and the delay line are the only state. Undelayed outputs decode combinationally from the counter registers, so there is zero latency relative to the counters.
- A counter changes on the i_clk edge where i_clkenable=1. With i_clkenable held high, one line takes H_TOTAL cycles and one frame takes H_TOTAL*V_TOTAL cycles.
- Reset values (i_rst_n low):
  - Counters at 0, so o_x=0, o_y=0, o_active=1, o_blanking=0, o_hs=~HS_POL, o_vs=~VS_POL.
  - o_frame_cnt=0; all strobes 0.
  - Delayed outputs at idle values.
- Reset asserted mid-frame takes effect immediately (async). The first pixel after release is (0,0) and o_frame_start fires on the first enabled tick.
- With i_clkenable low, all outputs hold and strobes stay 0.
- o_hs_d/o_vs_d/o_active_d equal o_hs/o_vs/o_active from exactly PIPE_DLY enabled ticks earlier.

## Structure
- Shared package vga_timing_pkg holds the mode constant sets (640x480@25.175 default, 800x600@40) and a timing-parameter struct typedef.
- Sub-module vga_delay_line(WIDTH, DEPTH, IDLE) provides an enable-gated shift register with async reset and synchronous flush, reused by the renderer.

## Test plan
- Default params, i_clkenable=1 for 2 frames:
  - o_hs low for exactly 96 cycles starting at h=656.
  - o_vs low on lines 490-491.
  - 800*525=420000 cycles per frame; o_frame_cnt 0→1→2.
- i_clkenable 1-in-4:
  - each line takes 3200 cycles.
  - strobes stay one i_clk cycle wide.
- i_restart at h=300, v=200:
  - next enabled tick shows o_x=0, o_y=0 with o_frame_start=1.
  - delayed outputs return idle for PIPE_DLY ticks.
  - o_frame_cnt unchanged.
- HS_POL=1, VS_POL=1, H_ACTIVE=8, H_FP=H_SYNC=H_BP=2, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1:
  - o_hs high for h=10..11.
  - o_animate at h=13, v=3.
  - o_screenend at h=13, v=6.
- PIPE_DLY=0 and 3: o_active_d equals o_active delayed by 0 and 3 enabled ticks respectively.
- FRAME_W=2, run 5 frames: o_frame_cnt sequence 1,2,3,0,1; async reset mid-line forces all documented reset values within the same cycle.
